// File: rtl/fetch_stage.sv
// F stage of the 5-stage MIPS pipeline: PC register, next-PC select,
// instruction fetch and AdEL detection on the fetch address.
module fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_LO     = 32'h0000_3000,
    parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] npc_branch,
    input  logic [31:0] npc_jump,
    input  logic [31:0] npc_jr,
    input  logic        jump_in_D,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] InstrF,
    output logic [31:0] PC_4F,
    output logic [6:2]  ExcCodeF,
    output logic        if_bdF
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic        fault;

    assign pc_plus4 = pc_q + 32'd4;

    // Redirects (exception entry, eret) bypass the stall so they are never lost.
    always_comb begin
        pc_d = pc_q;
        if (exc_req) begin
            pc_d = EXC_ENTRY;
        end else if (eret) begin
            pc_d = epc;
        end else if (en) begin
            unique case (pc_sel)
                2'd0: pc_d = pc_plus4;
                2'd1: pc_d = npc_branch;
                2'd2: pc_d = npc_jump;
                2'd3: pc_d = npc_jr;
                default: pc_d = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign fault = (pc_q[1:0] != 2'b00) | (pc_q < IM_LO) | (pc_q > IM_HI);

    always_comb begin
        InstrF   = imem_rdata;
        ExcCodeF = 5'd0;
        if (fault) begin
            InstrF   = 32'h0;
            ExcCodeF = 5'd4;
        end
    end

    assign imem_addr = pc_q;
    assign PCF       = pc_q;
    assign PC_4F     = pc_plus4;
    assign if_bdF    = jump_in_D;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- F-stage of the 5-stage MIPS pipeline with exceptions.
- Holds the program counter and selects the next PC (sequential, branch, jump, jr, exception entry, eret).
- Fetches through the instruction-memory port and flags fetch address faults (AdEL).
- Drives InstrF, PC_4F, ExcCodeF and if_bdF into the F/D pipeline register.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- EXC_ENTRY, 32'h0000_4180, exception handler entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  PC update enable; 0 = stall from hazard unit.
- pc_sel  input  2  next-PC source: 0 PC+4, 1 branch target, 2 jump target, 3 jr register.
- npc_branch  input  32  branch target computed in D.
- npc_jump  input  32  j/jal target computed in D.
- npc_jr  input  32  forwarded rs value for jr/jalr.
- jump_in_D  input  1  instruction currently in D is a branch/jump.
- exc_req  input  1  CP0 requests exception/interrupt entry.
- eret  input  1  eret committing; redirect to EPC.
- epc  input  32  EPC from CP0.
- imem_addr  output  32  fetch address (equals current PC).
- imem_rdata  input  32  instruction word, combinational read.
- PCF  output  32  current PC.
- InstrF  output  32  fetched instruction, or 0 on fault.
- PC_4F  output  32  PCF + 4.
- ExcCodeF  output  5 ([6:2])  5'd4 (AdEL) on fetch fault, else 0.
- if_bdF  output  1  fetched instruction is in a delay slot.

Behaviour:
- Single state register PC (32 bits). All outputs are combinational from PC and inputs.
- Reset: on posedge clk with reset=1, PC <= PC_RESET. Reset has priority over all other inputs. After reset, PCF=32'h3000, PC_4F=32'h3004, ExcCodeF=0 (given legal imem data).
- Next-PC priority on each posedge (highest first):
  1. reset
  2. exc_req: PC <= EXC_ENTRY
  3. eret: PC <= epc
  4. en=0: PC holds
  5. pc_sel: 0 PC+4, 1 npc_branch, 2 npc_jump, 3 npc_jr
- exc_req and eret override en=0; redirects are never lost to a stall.
- If exc_req and eret are both asserted, exc_req wins.
- PC+4 wraps modulo 2^32 with no flag.
- Fault detection: fault = (PC[1:0] != 0) | (PC < IM_LO) | (PC > IM_HI), unsigned compares.
  - On fault: InstrF = 32'h0 (nop), ExcCodeF = 5'd4.
  - Otherwise: InstrF = imem_rdata, ExcCodeF = 5'd0.
- imem_addr = PC regardless of fault; memory must tolerate any address.
- if_bdF = jump_in_D, passed through combinationally. Exception logic uses it to set EPC = PC-4 for delay-slot faults.
- A faulting PC is not corrected. It stays in the pipeline until exc_req redirects it, or holds under en=0.
- No internal multi-cycle state; fetch latency is 0 cycles (combinational IM).

Test Plan:
1. Reset held 2 cycles, then released with pc_sel=0, en=1 -> PCF goes 3000, 3004, 3008 on consecutive cycles; ExcCodeF=0; InstrF tracks imem_rdata.
2. en=0 for 3 cycles at PCF=300C -> PCF stays 300C. Then en=1 with pc_sel=1, npc_branch=3040 -> PCF=3040 next cycle.
3. pc_sel=3, npc_jr=32'h3002 -> next PCF=3002; InstrF=0, ExcCodeF=4 even with imem_rdata=32'h24010001. Then exc_req=1 -> PCF=4180, ExcCodeF=0.
4. pc_sel=2, npc_jump=32'h7000 -> ExcCodeF=4 (above IM_HI). Repeat with npc_jump=32'h2FFC -> ExcCodeF=4. Repeat with npc_jump=32'h6FFC -> ExcCodeF=0.
5. en=0 with exc_req=1 and eret=1 in the same cycle -> PCF=4180 (exception wins over eret and stall). Next cycle eret=1, epc=32'h3010, en=0 -> PCF=3010.
6. jump_in_D=1 -> if_bdF=1 in the same cycle; jump_in_D=0 -> if_bdF=0. Assert reset mid-run at PCF=4188 -> PCF=3000 next cycle.
